// File: rtl/lsu_stage_if.sv
// Bundle of upstream, branch, memory and writeback signals for lsu_stage.
// The slave modport is the stage itself; the master modport is its environment.
interface lsu_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int REG_SEL   = 5,
  parameter int ADDR_SIZE = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [WORD_SIZE-1:0]   result;
  logic [WORD_SIZE-1:0]   save_data;
  logic [REG_SEL-1:0]     rd;
  logic                   reg_write;
  logic                   mem_read;
  logic                   mem_write;
  logic                   branch;
  logic                   jump;
  logic                   zero;
  logic                   data_sign;
  logic [1:0]             data_size;
  logic                   pc_src;
  logic                   m_req;
  logic                   m_we;
  logic [ADDR_SIZE-1:0]   m_addr;
  logic [WORD_SIZE-1:0]   m_wdata;
  logic [WORD_SIZE/8-1:0] m_be;
  logic                   m_ack;
  logic [WORD_SIZE-1:0]   m_rdata;
  logic                   out_valid;
  logic                   reg_write_out;
  logic [REG_SEL-1:0]     rd_out;
  logic [WORD_SIZE-1:0]   read_data;
  logic [WORD_SIZE-1:0]   result_out;
  logic                   fault;
  logic [ADDR_SIZE-1:0]   fault_addr;

  modport slave (
    input  in_valid, result, save_data, rd, reg_write, mem_read, mem_write,
           branch, jump, zero, data_sign, data_size, m_ack, m_rdata,
    output in_ready, pc_src, m_req, m_we, m_addr, m_wdata, m_be,
           out_valid, reg_write_out, rd_out, read_data, result_out, fault, fault_addr
  );

  modport master (
    output in_valid, result, save_data, rd, reg_write, mem_read, mem_write,
           branch, jump, zero, data_sign, data_size, m_ack, m_rdata,
    input  in_ready, pc_src, m_req, m_we, m_addr, m_wdata, m_be,
           out_valid, reg_write_out, rd_out, read_data, result_out, fault, fault_addr
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage: captures one op, runs one memory handshake with timeout, then pulses writeback.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of aligning them down.
module lsu_stage #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int REG_SEL   = $clog2(NUM_REGS),
  parameter int ADDR_SIZE = 10,
  parameter int TIMEOUT   = 16
) (
  input logic        clk,
  input logic        rst,
  lsu_stage_if.slave bus
);
  localparam int NBYTES = WORD_SIZE / 8;
  localparam int OFFW   = $clog2(NBYTES);
  localparam int CNTW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic [REG_SEL-1:0]   rd_q, rd_d;
  logic                 regw_q, regw_d, load_q, load_d, sign_q, sign_d;
  logic [1:0]           size_q, size_d;
  logic [OFFW-1:0]      off_q, off_d;
  logic                 m_req_q, m_req_d, m_we_q, m_we_d;
  logic [ADDR_SIZE-1:0] m_addr_q, m_addr_d, fault_addr_q, fault_addr_d;
  logic [WORD_SIZE-1:0] m_wdata_q, m_wdata_d, read_data_q, read_data_d;
  logic [NBYTES-1:0]    m_be_q, m_be_d;
  logic                 out_valid_q, out_valid_d, regwo_q, regwo_d, fault_q, fault_d;

  logic                 memOp, sizeIllegal, earlyFault;
  logic [OFFW-1:0]      offRaw, alignMask, offUse;
  logic [NBYTES-1:0]    beNew;
  logic [WORD_SIZE-1:0] wdataNew, shifted, widened, loadExt;
  int                   nbits, shamt;

  assign bus.pc_src   = (bus.branch && bus.zero) || bus.jump;
  assign bus.in_ready = rst && (state_q == IDLE);

  // Lane placement of the incoming op, and faults detectable before touching memory.
  always_comb begin
    memOp       = bus.mem_read | bus.mem_write;
    offRaw      = bus.result[OFFW-1:0];
    alignMask   = {OFFW{1'b1}} << bus.data_size;
    sizeIllegal = (WORD_SIZE < 64) && (bus.data_size == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
    offUse     = offRaw;
    earlyFault = memOp && ((bus.mem_read && bus.mem_write) || sizeIllegal ||
                           (|(offRaw & ~alignMask)));
`else
    offUse     = offRaw & alignMask;
    earlyFault = memOp && ((bus.mem_read && bus.mem_write) || sizeIllegal);
`endif
    for (int i = 0; i < NBYTES; i++)
      beNew[i] = (i >= int'(offUse)) && (i < int'(offUse) + (1 << bus.data_size));
    wdataNew = bus.save_data << {offUse, 3'b000};
  end

  // Push the loaded field to the top, then shift back down arithmetically or logically to extend.
  always_comb begin
    shifted = bus.m_rdata >> {off_q, 3'b000};
    nbits   = 8 << size_q;
    shamt   = (nbits >= WORD_SIZE) ? 0 : WORD_SIZE - nbits;
    widened = shifted << shamt;
    if (sign_q) loadExt = widened >> shamt;
    else        loadExt = $signed(widened) >>> shamt;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    rd_d         = rd_q;
    regw_d       = regw_q;
    load_d       = load_q;
    sign_d       = sign_q;
    size_d       = size_q;
    off_d        = off_q;
    m_req_d      = 1'b0;
    m_we_d       = 1'b0;
    m_addr_d     = '0;
    m_wdata_d    = '0;
    m_be_d       = '0;
    out_valid_d  = 1'b0;
    regwo_d      = 1'b0;
    read_data_d  = '0;
    fault_d      = 1'b0;
    fault_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          result_d = bus.result;
          rd_d     = bus.rd;
          regw_d   = bus.reg_write;
          load_d   = bus.mem_read;
          sign_d   = bus.data_sign;
          size_d   = bus.data_size;
          off_d    = offUse;
          if (earlyFault) begin
            state_d      = DONE;
            out_valid_d  = 1'b1;
            fault_d      = 1'b1;
            fault_addr_d = bus.result[ADDR_SIZE-1:0];
          end else if (memOp) begin
            state_d   = WAIT;
            cnt_d     = '0;
            m_req_d   = 1'b1;
            m_we_d    = bus.mem_write;
            m_addr_d  = {bus.result[ADDR_SIZE-1:OFFW], {OFFW{1'b0}}};
            m_wdata_d = wdataNew;
            m_be_d    = beNew;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            regwo_d     = bus.reg_write;
          end
        end
      end
      WAIT: begin
        // An acknowledge arriving on the final allowed cycle still completes normally.
        if (bus.m_ack) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          regwo_d     = regw_q;
          read_data_d = load_q ? loadExt : '0;
        end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
          state_d      = DONE;
          out_valid_d  = 1'b1;
          fault_d      = 1'b1;
          fault_addr_d = result_q[ADDR_SIZE-1:0];
        end else begin
          cnt_d     = cnt_q + 1'b1;
          m_req_d   = 1'b1;
          m_we_d    = m_we_q;
          m_addr_d  = m_addr_q;
          m_wdata_d = m_wdata_q;
          m_be_d    = m_be_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      result_q     <= '0;
      rd_q         <= '0;
      regw_q       <= 1'b0;
      load_q       <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= '0;
      off_q        <= '0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
      out_valid_q  <= 1'b0;
      regwo_q      <= 1'b0;
      read_data_q  <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      rd_q         <= rd_d;
      regw_q       <= regw_d;
      load_q       <= load_d;
      sign_q       <= sign_d;
      size_q       <= size_d;
      off_q        <= off_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
      out_valid_q  <= out_valid_d;
      regwo_q      <= regwo_d;
      read_data_q  <= read_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.m_req         = m_req_q;
  assign bus.m_we          = m_we_q;
  assign bus.m_addr        = m_addr_q;
  assign bus.m_wdata       = m_wdata_q;
  assign bus.m_be          = m_be_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.reg_write_out = regwo_q;
  assign bus.rd_out        = rd_q;
  assign bus.read_data     = read_data_q;
  assign bus.result_out    = result_q;
  assign bus.fault         = fault_q;
  assign bus.fault_addr    = fault_addr_q;
endmodule

// File: tb/tb_lsu_stage.sv
// Directed and random checks of lsu_stage against a byte-level reference model.
// Expectations follow LSU_MISALIGN_TRAP_EN when the bench is built with it.
module tb_lsu_stage;
  localparam int WS = 32;
  localparam int RS = 5;
  localparam int AS = 10;
  localparam int TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAPEN = 1'b1;
`else
  localparam bit TRAPEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  lsu_stage_if #(.WORD_SIZE(WS), .REG_SEL(RS), .ADDR_SIZE(AS)) bus ();

  lsu_stage #(.WORD_SIZE(WS), .NUM_REGS(32), .REG_SEL(RS), .ADDR_SIZE(AS), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr, save, rdata;
    logic [4:0]  rd;
    logic        regw, memr, memw, br, jmp, zr, sgn;
    logic [1:0]  sz;
    int          ackEdge;
  } op_t;

  typedef struct {
    int          reqCycles;
    int          outCycle;
    logic        fault;
    logic [9:0]  faultAddr, mAddr;
    logic        regwOut;
    logic [31:0] readData, wdata;
    logic [3:0]  be;
  } exp_t;

  function automatic op_t mkOp(input logic [31:0] addr, save, rdata, input logic [4:0] rd,
                               input logic regw, memr, memw, br, jmp, zr, sgn,
                               input logic [1:0] sz, input int ackEdge);
    op_t o;
    o.addr = addr; o.save = save; o.rdata = rdata; o.rd = rd; o.regw = regw;
    o.memr = memr; o.memw = memw; o.br = br; o.jmp = jmp; o.zr = zr; o.sgn = sgn;
    o.sz = sz; o.ackEdge = ackEdge;
    return o;
  endfunction

  // Reference: treat memory as bytes and the access as n bytes starting at a byte offset.
  function automatic exp_t model(input op_t op);
    exp_t   e;
    longint a, raw;
    int     n, bits, off;
    bit     memOp, early, acked;
    a     = {32'h0, op.addr};
    n     = 1 << op.sz;
    bits  = 8 * n;
    memOp = op.memr || op.memw;
    early = memOp && ((op.memr && op.memw) || (op.sz == 2'd3) || (TRAPEN && (a % n != 0)));
    acked = memOp && !early && op.ackEdge >= 1 && op.ackEdge <= TO;
    off   = int'(a % 4);
    if (!TRAPEN) off = off - off % n;
    e.reqCycles = (!memOp || early) ? 0 : (acked ? op.ackEdge : TO);
    e.outCycle  = e.reqCycles + 1;
    e.fault     = memOp && !acked;
    e.faultAddr = e.fault ? 10'(a % 1024) : 10'd0;
    e.mAddr     = 10'((a % 1024) / 4 * 4);
    e.be        = 4'(((1 << n) - 1) << off);
    e.wdata     = 32'({32'h0, op.save} << (8 * off));
    raw = {32'h0, op.rdata} >> (8 * off);
    if (bits < 32) begin
      raw = raw % (64'd1 << bits);
      if (!op.sgn && raw >= (64'd1 << (bits - 1))) raw = raw - (64'd1 << bits);
    end
    e.readData = (op.memr && !e.fault) ? 32'(raw) : 32'd0;
    e.regwOut  = e.fault ? 1'b0 : op.regw;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input string tag, input op_t op);
    exp_t e;
    int   reqSeen;
    bit   done;
    e       = model(op);
    reqSeen = 0;
    done    = 1'b0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.result    = op.addr;
    bus.save_data = op.save;
    bus.rd        = op.rd;
    bus.reg_write = op.regw;
    bus.mem_read  = op.memr;
    bus.mem_write = op.memw;
    bus.branch    = op.br;
    bus.jump      = op.jmp;
    bus.zero      = op.zr;
    bus.data_sign = op.sgn;
    bus.data_size = op.sz;
    bus.m_rdata   = op.rdata;
    bus.m_ack     = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".in_ready"}, bus.in_ready, 1);
    checkOutput({tag, ".pc_src"}, bus.pc_src, (op.br && op.zr) || op.jmp);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.result    = $urandom;
    bus.save_data = $urandom;
    bus.rd        = 5'($urandom);
    bus.reg_write = ~op.regw;
    bus.data_sign = ~op.sgn;
    for (int k = 1; k <= 40 && !done; k++) begin
      bus.m_ack = (k == op.ackEdge);
      @(negedge clk);
      if (bus.out_valid) begin
        done = 1'b1;
        checkOutput({tag, ".latency"}, k, e.outCycle);
        checkOutput({tag, ".req_cycles"}, reqSeen, e.reqCycles);
        checkOutput({tag, ".m_req_dropped"}, bus.m_req, 0);
        checkOutput({tag, ".fault"}, bus.fault, e.fault);
        checkOutput({tag, ".fault_addr"}, bus.fault_addr, e.faultAddr);
        checkOutput({tag, ".reg_write_out"}, bus.reg_write_out, e.regwOut);
        checkOutput({tag, ".read_data"}, bus.read_data, e.readData);
        checkOutput({tag, ".rd_out"}, bus.rd_out, op.rd);
        checkOutput({tag, ".result_out"}, bus.result_out, op.addr);
      end else begin
        if (bus.m_req) begin
          reqSeen++;
          checkOutput({tag, ".m_addr"}, bus.m_addr, e.mAddr);
          checkOutput({tag, ".m_be"}, bus.m_be, e.be);
          checkOutput({tag, ".m_we"}, bus.m_we, op.memw);
          checkOutput({tag, ".m_wdata"}, bus.m_wdata, e.wdata);
        end
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, ".completed"}, done, 1);
    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    @(negedge clk);
    checkOutput({tag, ".pulse_ends"}, bus.out_valid, 0);
    checkOutput({tag, ".fault_ends"}, bus.fault, 0);
    checkOutput({tag, ".idle_req"}, bus.m_req, 0);
    checkOutput({tag, ".idle_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    op_t op;
    int  kind;
    bus.in_valid = 1'b0; bus.result = '0; bus.save_data = '0; bus.rd = '0;
    bus.reg_write = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.branch = 1'b0; bus.jump = 1'b0; bus.zero = 1'b0; bus.data_sign = 1'b0;
    bus.data_size = 2'd0; bus.m_ack = 1'b0; bus.m_rdata = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst.in_ready", bus.in_ready, 0);
    checkOutput("rst.out_valid", bus.out_valid, 0);
    checkOutput("rst.m_req", bus.m_req, 0);
    checkOutput("rst.m_be", bus.m_be, 0);
    checkOutput("rst.m_addr", bus.m_addr, 0);
    checkOutput("rst.m_wdata", bus.m_wdata, 0);
    checkOutput("rst.fault", bus.fault, 0);
    checkOutput("rst.read_data", bus.read_data, 0);
    checkOutput("rst.result_out", bus.result_out, 0);
    checkOutput("rst.rd_out", bus.rd_out, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst.release_ready", bus.in_ready, 1);

    applyStimulus("branch", mkOp(32'h1234_5678, 32'h0, 32'h0, 5'd7, 1, 0, 0, 1, 0, 1, 0, 2'd2, 0));
    applyStimulus("lb_signed", mkOp(32'h003, 32'h5555_5555, 32'h80FF_FFFF, 5'd3, 1, 1, 0, 0, 0, 0, 0, 2'd0, 3));
    applyStimulus("sh_store", mkOp(32'h006, 32'h0000_ABCD, 32'h1111_2222, 5'd4, 0, 0, 1, 0, 0, 0, 0, 2'd1, 1));
    applyStimulus("lw_timeout", mkOp(32'h100, 32'h0, 32'hCAFE_F00D, 5'd9, 1, 1, 0, 0, 0, 0, 0, 2'd2, 0));
    applyStimulus("lw_misaligned", mkOp(32'h002, 32'h0, 32'hDEAD_BEEF, 5'd10, 1, 1, 0, 0, 0, 0, 0, 2'd2, 2));
    applyStimulus("ack_last_cycle", mkOp(32'h204, 32'h0, 32'h7654_3210, 5'd11, 1, 1, 0, 0, 0, 0, 0, 2'd2, 16));
    applyStimulus("ack_too_late", mkOp(32'h208, 32'h0, 32'h7654_3210, 5'd12, 1, 1, 0, 0, 0, 0, 0, 2'd2, 17));
    applyStimulus("rw_both", mkOp(32'h010, 32'h0, 32'h0, 5'd13, 1, 1, 1, 0, 0, 0, 0, 2'd2, 1));
    applyStimulus("dword", mkOp(32'h018, 32'h0, 32'h0, 5'd14, 1, 1, 0, 0, 0, 0, 0, 2'd3, 1));
    applyStimulus("lhu", mkOp(32'h00A, 32'h0, 32'h8001_1234, 5'd15, 1, 1, 0, 0, 0, 0, 1, 2'd1, 2));
    applyStimulus("jump", mkOp(32'h0000_0040, 32'h0, 32'h0, 5'd1, 0, 0, 0, 0, 1, 0, 0, 2'd0, 1));

    // Reset lands on the second WAIT cycle; the following acknowledge must be ignored.
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.result = 32'h040; bus.mem_read = 1'b1; bus.mem_write = 1'b0;
    bus.data_size = 2'd2; bus.reg_write = 1'b1; bus.branch = 1'b0; bus.jump = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rstwait.m_req", bus.m_req, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.jump = 1'b1;
    @(negedge clk);
    checkOutput("rstwait.pc_src", bus.pc_src, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.m_ack = 1'b1;
    bus.jump = 1'b0;
    @(negedge clk);
    checkOutput("rstwait.in_ready", bus.in_ready, 1);
    checkOutput("rstwait.m_req_drop", bus.m_req, 0);
    checkOutput("rstwait.out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    bus.m_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rstwait.no_valid", bus.out_valid, 0);
      checkOutput("rstwait.no_req", bus.m_req, 0);
    end

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 9);
      op = mkOp($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0,
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom_range(0, 2)), 0);
      if (kind >= 2 && kind <= 5) op.memr = 1'b1;
      if (kind >= 6 && kind <= 8) op.memw = 1'b1;
      if (kind == 9) begin op.memr = 1'b1; op.memw = 1'b1; end
      if ($urandom_range(0, 9) == 0) op.sz = 2'd3;
      op.ackEdge = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 5));
      applyStimulus("random", op);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 The module SHALL have parameters: WORD_SIZE, default 32, datapath width (multiple of 8, 32 or 64); NUM_REGS, default 32, register count; REG_SEL, default $clog2(NUM_REGS), rd width; ADDR_SIZE, default 10, memory byte-address width; TIMEOUT, default 16, max wait cycles for m_ack (>=1).
REQ-002 The module SHALL be clocked by clk with a single clock domain, and reset rst SHALL be synchronous and active-low.
REQ-003 Ports (name dir width meaning): clk in 1 clock; rst in 1 sync active-low reset.
REQ-004 The upstream ports SHALL be: in_valid in 1 op present; in_ready out 1 stage can accept; result in WORD_SIZE ALU result/address; save_data in WORD_SIZE store data; rd in REG_SEL destination; reg_write, mem_read, mem_write, branch, jump, zero in 1 each; data_sign in 1 (0 signed, 1 unsigned); data_size in 2 (0 byte, 1 half, 2 word, 3 dword, legal only if WORD_SIZE=64).
REQ-005 The branch port SHALL be: pc_src out 1 branch/jump taken.
REQ-006 The memory ports SHALL be: m_req out 1; m_we out 1; m_addr out ADDR_SIZE; m_wdata out WORD_SIZE lane-shifted; m_be out WORD_SIZE/8 byte enables; m_ack in 1; m_rdata in WORD_SIZE full aligned word.
REQ-007 The writeback ports SHALL be: out_valid out 1 one-cycle pulse; reg_write_out out 1; rd_out out REG_SEL; read_data out WORD_SIZE extended load data; result_out out WORD_SIZE; fault out 1; fault_addr out ADDR_SIZE.

Function
REQ-008 pc_src SHALL equal (branch && zero) || jump combinationally on the inputs, independent of state.
REQ-009 The FSM SHALL have states IDLE, WAIT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-010 An op SHALL be accepted on an edge where in_valid && in_ready; all inputs SHALL be captured into internal registers at acceptance.
REQ-011 A non-memory op (mem_read=mem_write=0) SHALL go IDLE->DONE, giving out_valid the cycle after accept with read_data=0 and the captured result/rd/reg_write.
REQ-012 A memory op SHALL go IDLE->WAIT; in WAIT, m_req=1 with m_we, m_addr, m_wdata, and m_be held stable until m_ack or timeout.
REQ-013 On m_ack in WAIT, the FSM SHALL go to DONE, m_req SHALL drop the next cycle, and out_valid SHALL pulse in DONE; the minimum accept-to-out_valid latency SHALL be 2 cycles.
REQ-014 DONE SHALL always return to IDLE after one cycle; there is no downstream backpressure.
REQ-015 m_addr SHALL equal the word-aligned captured result[ADDR_SIZE-1:0], with the low log2(WORD_SIZE/8) bits zeroed.
REQ-016 m_be SHALL have 2^data_size contiguous bits set starting at the byte offset; m_wdata SHALL be save_data shifted left by offset*8.
REQ-017 Load data SHALL be m_rdata shifted right by offset*8, truncated to size, then sign-extended (data_sign=0) or zero-extended (data_sign=1); for stores, read_data SHALL be 0.
REQ-018 The WAIT counter SHALL reset on entry; if it reaches TIMEOUT with no m_ack, the FSM SHALL go to DONE with fault=1, fault_addr=captured address, reg_write_out=0, and m_req dropped.
REQ-019 mem_read && mem_write together, or data_size=3 with WORD_SIZE=32, SHALL fault without asserting m_req, with out_valid the cycle after accept.
REQ-020 m_ack outside WAIT SHALL be ignored; m_ack on the timeout cycle SHALL win, with no fault.
REQ-021 Any faulting op SHALL force reg_write_out=0; fault SHALL be valid only while out_valid=1 and 0 otherwise.

Reset
REQ-022 While rst=0 at an edge, the state SHALL be IDLE and the counter 0, and all registered outputs (out_valid, reg_write_out, rd_out, read_data, result_out, fault, fault_addr, m_req, m_we, m_addr, m_wdata, m_be) SHALL be 0.
REQ-023 A reset during WAIT SHALL abort the transaction, drop m_req, and cause no out_valid; a late m_ack after reset SHALL be ignored.
REQ-024 in_ready SHALL be 0 while rst=0 and 1 on the first cycle after release.

Configuration
REQ-025 The macro LSU_MISALIGN_TRAP_EN SHALL select misaligned-access handling; misaligned means the address is not a multiple of 2^data_size.
REQ-026 With LSU_MISALIGN_TRAP_EN defined, a misaligned memory op SHALL never assert m_req and SHALL fault (fault_addr = unaligned address) the cycle after accept.
REQ-027 With LSU_MISALIGN_TRAP_EN undefined, the offset SHALL be aligned down to the size boundary, the access SHALL proceed normally, and fault SHALL never assert for misalignment.

Verification
REQ-028 The bench SHALL cover a signed byte load at addr 0x003 with m_rdata=0x80FF_FFFF, m_ack 3 cycles after m_req, giving m_be=1000, read_data=0xFFFF_FF80, out_valid 4 cycles after accept.
REQ-029 The bench SHALL cover a half store of save_data=0x0000_ABCD at 0x006, giving m_we=1, m_be=1100, m_wdata=0xABCD_0000, and reg_write_out=0.
REQ-030 The bench SHALL cover a load with m_ack never asserted and TIMEOUT=16, giving m_req high for exactly 16 cycles then fault=1, fault_addr=address, reg_write_out=0.
REQ-031 The bench SHALL cover a word load at 0x002 with LSU_MISALIGN_TRAP_EN defined (fault=1, m_req never high) and undefined (m_addr=0x000, m_be=1111, fault=0).
REQ-032 The bench SHALL cover rst=0 on the second WAIT cycle followed by m_ack the next cycle, giving no out_valid and in_ready=1 after release.
REQ-033 The bench SHALL cover a non-memory op with branch=1, zero=1, giving pc_src=1 the same cycle and out_valid the next cycle with result_out=result.
